dm_responder: RTL and testbench

//  Memory-side responder for the core's data-memory port. Accepts one load/store request,

---
 rtl/dm_responder_pkg.sv | 24 ++
 rtl/dm_lane_align.sv | 58 +++++
 rtl/dm_responder.sv | 138 +++++++++++++
 tb/tb_dm_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared FSM state type and RV32 load/store funct3 codes for the data-memory responder.
package dm_responder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } dmState_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic isStoreF3(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   function automatic logic isLoadF3(input logic [2:0] f3);
      return isStoreF3(f3) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for a word of four byte lanes: store strobes and data
// shift, load extract with sign/zero extension, and alignment/funct3 legality.
module dm_lane_align
   import dm_responder_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      lane_i,
   input  logic [2:0]      f3_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rword_i,
   output logic [3:0]      strobe_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misaligned_o,
   output logic            storeF3Ok_o,
   output logic            loadF3Ok_o
);

   logic [4:0]      shamt;
   logic [XLEN-1:0] rShifted;
   logic [7:0]      rByte;
   logic [15:0]     rHalf;

   assign shamt    = {lane_i, 3'b000};
   assign wdata_o  = wdata_i << shamt;
   assign rShifted = rword_i >> shamt;
   assign rByte    = rShifted[7:0];
   assign rHalf    = rShifted[15:0];

   assign misaligned_o = ((f3_i[1:0] == 2'b01) && lane_i[0]) ||
                         ((f3_i[1:0] == 2'b10) && (lane_i != 2'b00));
   assign storeF3Ok_o  = isStoreF3(f3_i);
   assign loadF3Ok_o   = isLoadF3(f3_i);

   always_comb begin
      strobe_o = 4'b0000;
      unique case (f3_i[1:0])
         2'b00:   strobe_o = 4'b0001 << lane_i;
         2'b01:   strobe_o = 4'b0011 << lane_i;
         2'b10:   strobe_o = 4'b1111;
         default: strobe_o = 4'b0000;
      endcase
   end

   always_comb begin
      rdata_o = '0;
      unique case (f3_i)
         F3_B:    rdata_o = {{(XLEN-8){rByte[7]}}, rByte};
         F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, rByte};
         F3_H:    rdata_o = {{(XLEN-16){rHalf[15]}}, rHalf};
         F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, rHalf};
         F3_W:    rdata_o = rShifted;
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then commits or
// reads the word RAM and pulses o_DM_data_ready for one cycle.
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR   = '0,
   parameter int              LATENCY     = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_DM_Addr,
   input  logic [XLEN-1:0] i_DM_Wd,
   input  logic [2:0]      i_DM_f3,
   input  logic            i_DM_Wen,
   input  logic            i_DM_MemRead,
   output logic [XLEN-1:0] o_DM_ReadData,
   output logic            o_DM_data_ready,
   output logic            o_DM_err
);

   localparam int            AW   = $clog2(DEPTH_WORDS);
   localparam int            CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [XLEN:0] SPAN = (XLEN+1)'(4 * DEPTH_WORDS);

   dmState_e        stateQ, stateD;
   logic [CW-1:0]   cntQ, cntD;
   logic [XLEN-1:0] addrQ, wdQ;
   logic [2:0]      f3Q;
   logic            wenQ, rdQ;

   logic            req;
   logic [XLEN:0]   offset;
   logic [AW-1:0]   wordIdx;
   logic            outOfRange, misaligned, storeOk, loadOk, accessErr, commit;
   logic [3:0]      strobe;
   logic [XLEN-1:0] wdataShift, rdataAligned, memWord;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   assign req = i_DM_Wen | i_DM_MemRead;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         stateQ <= StIdle;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   // The request level must stay up through WAIT; a drop abandons the access.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (req) begin
               cntD   = CW'(LATENCY - 1);
               stateD = (LATENCY == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            if (!req) begin
               stateD = StIdle;
            end else begin
               cntD = cntQ - CW'(1);
               if (cntQ == CW'(1)) stateD = StResp;
            end
         end
         StResp:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         addrQ <= '0;
         wdQ   <= '0;
         f3Q   <= '0;
         wenQ  <= 1'b0;
         rdQ   <= 1'b0;
      end else if ((stateQ == StIdle) && req) begin
         addrQ <= i_DM_Addr;
         wdQ   <= i_DM_Wd;
         f3Q   <= i_DM_f3;
         wenQ  <= i_DM_Wen;
         rdQ   <= i_DM_MemRead;
      end
   end

   assign offset     = {1'b0, addrQ} - {1'b0, BASE_ADDR};
   assign outOfRange = (addrQ < BASE_ADDR) || (offset >= SPAN);
   assign wordIdx    = offset[AW+1:2];
   assign memWord    = mem[wordIdx];

   dm_lane_align #(
      .XLEN(XLEN)
   ) u_align (
      .lane_i      (addrQ[1:0]),
      .f3_i        (f3Q),
      .wdata_i     (wdQ),
      .rword_i     (memWord),
      .strobe_o    (strobe),
      .wdata_o     (wdataShift),
      .rdata_o     (rdataAligned),
      .misaligned_o(misaligned),
      .storeF3Ok_o (storeOk),
      .loadF3Ok_o  (loadOk)
   );

   assign accessErr = outOfRange | misaligned | (wenQ & rdQ) |
                      (wenQ ? !storeOk : !loadOk);
   assign commit    = (stateQ == StResp) && wenQ && !accessErr;

   // RAM array deliberately has no reset so contents survive it.
   always_ff @(posedge i_clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (strobe[b]) mem[wordIdx][8*b +: 8] <= wdataShift[8*b +: 8];
         end
      end
   end

   always_comb begin
      o_DM_data_ready = 1'b0;
      o_DM_err        = 1'b0;
      o_DM_ReadData   = '0;
      if (stateQ == StResp) begin
         o_DM_data_ready = 1'b1;
         o_DM_err        = accessErr;
         if (rdQ && !accessErr) o_DM_ReadData = rdataAligned;
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, multi-cycle abort/reset
// sequences, and randomized accesses checked against a byte-array memory model.
module tb_dm_responder;

   localparam int          LAT   = 3;
   localparam int          DEPTH = 256;
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

   logic        clk, rstN, dmWen, dmRead, ready, err;
   logic [31:0] dmAddr, dmWd, rdata;
   logic [2:0]  dmF3;

   int tests = 0;
   int fails = 0;

   logic [7:0] refMem [DEPTH*4];

   typedef struct {
      logic        wen;
      logic        rd;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        expErr;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[$];

   dm_responder #(
      .XLEN       (32),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (32'h0),
      .LATENCY    (LAT)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rstN),
      .i_DM_Addr      (dmAddr),
      .i_DM_Wd        (dmWd),
      .i_DM_f3        (dmF3),
      .i_DM_Wen       (dmWen),
      .i_DM_MemRead   (dmRead),
      .o_DM_ReadData  (rdata),
      .o_DM_data_ready(ready),
      .o_DM_err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: little-endian byte memory with size/sign rules from funct3.
   function automatic void refAccess(input logic wen, input logic rd, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic expErr, output logic [31:0] expData);
      int          size;
      logic        legal;
      logic [31:0] v;
      size  = 1 << f3[1:0];
      legal = wen ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      expErr  = (wen && rd) || !legal || (addr >= SPAN) || ((addr % 32'(size)) != 32'd0);
      expData = '0;
      if (expErr) return;
      if (wen) begin
         for (int i = 0; i < size; i++) refMem[addr + 32'(i)] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v = v | (32'(refMem[addr + 32'(i)]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8*size));
         expData = v;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Waits (bounded) for the ready pulse; returns at the negedge where it is seen.
   task automatic waitReady(input string name, output int lat, output logic gotErr,
                            output logic [31:0] gotData);
      logic quietOk;
      quietOk = 1'b1;
      lat     = -1;
      gotErr  = 1'b0;
      gotData = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ready) begin
            lat     = k;
            gotErr  = err;
            gotData = rdata;
            break;
         end
         if (err !== 1'b0 || rdata !== 32'd0) quietOk = 1'b0;
      end
      checkOutput({name, " quiet-before-ready"}, 32'(quietOk), 32'd1);
   endtask

   task automatic checkQuiet(input string name, input int n);
      logic sawReady;
      sawReady = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (ready !== 1'b0) sawReady = 1'b1;
      end
      checkOutput(name, 32'(sawReady), 32'd0);
   endtask

   task automatic applyStimulus(input string name, input logic wen, input logic rd,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic gotErr,
                                output logic [31:0] gotData, output int lat);
      dmWen  = wen;
      dmRead = rd;
      dmF3   = f3;
      dmAddr = addr;
      dmWd   = wd;
      waitReady(name, lat, gotErr, gotData);
      dmWen  = 1'b0;
      dmRead = 1'b0;
      @(negedge clk);
      checkOutput({name, " single-pulse"}, 32'(ready), 32'd0);
   endtask

   task automatic doAccess(input string name, input logic wen, input logic rd,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic expErr, input logic [31:0] expData);
      logic        gotErr;
      logic [31:0] gotData;
      int          lat;
      applyStimulus(name, wen, rd, f3, addr, wd, gotErr, gotData, lat);
      checkOutput({name, " latency"}, 32'(lat), 32'(LAT));
      checkOutput({name, " err"}, 32'(gotErr), 32'(expErr));
      checkOutput({name, " data"}, gotData, expData);
   endtask

   initial begin
      logic        eErr, gErr;
      logic [31:0] eData, eData2, gData, addr, wd;
      logic [2:0]  f3;
      logic        wen, rd;
      int          lat, r, p;

      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h100, 32'h11223344, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h101, 32'hFFFFFFA5, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h101, 32'h0,        1'b0, 32'h000000A5});
      vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h101, 32'h0,        1'b0, 32'hFFFFFFA5});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        1'b0, 32'h1122A544});
      vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h102, 32'hABCD8001, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h102, 32'h0,        1'b0, 32'hFFFF8001});
      vecs.push_back('{1'b0, 1'b1, 3'b101, 32'h102, 32'h0,        1'b0, 32'h00008001});
      vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h101, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        1'b0, 32'h8001A544});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0BADF00D, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h3FC, 32'h0,        1'b0, 32'h0BADF00D});
      vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        1'b0, 32'h8001A544});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b011, 32'h100, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h100, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        1'b0, 32'h8001A544});
      vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h200, 32'h12345678, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 1'b1, 3'b101, 32'h202, 32'h0,        1'b0, 32'h00001234});

      dmWen  = 1'b0;
      dmRead = 1'b0;
      dmF3   = 3'b000;
      dmAddr = '0;
      dmWd   = '0;
      rstN   = 1'b1;
      #1 rstN = 1'b0;
      #12;
      checkOutput("reset ready", 32'(ready), 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);
      checkOutput("reset data", rdata, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      for (int w = 0; w < DEPTH; w++) begin
         wd = $urandom;
         refAccess(1'b1, 1'b0, 3'b010, 32'(w * 4), wd, eErr, eData);
         doAccess($sformatf("preload[%0d]", w), 1'b1, 1'b0, 3'b010, 32'(w * 4), wd, eErr, eData);
      end

      foreach (vecs[i]) begin
         refAccess(vecs[i].wen, vecs[i].rd, vecs[i].f3, vecs[i].addr, vecs[i].wd, eErr, eData);
         doAccess($sformatf("vec[%0d]", i), vecs[i].wen, vecs[i].rd, vecs[i].f3,
                  vecs[i].addr, vecs[i].wd, vecs[i].expErr, vecs[i].expData);
      end

      // Back-to-back loads held at level: next address presented during the ready cycle.
      refAccess(1'b0, 1'b1, 3'b010, 32'h0, 32'h0, eErr, eData);
      refAccess(1'b0, 1'b1, 3'b010, 32'h4, 32'h0, eErr, eData2);
      dmWen  = 1'b0;
      dmRead = 1'b1;
      dmF3   = 3'b010;
      dmAddr = 32'h0;
      waitReady("b2b first", lat, gErr, gData);
      checkOutput("b2b first latency", 32'(lat), 32'(LAT));
      checkOutput("b2b first data", gData, eData);
      dmAddr = 32'h4;
      waitReady("b2b second", lat, gErr, gData);
      checkOutput("b2b second gap", 32'(lat), 32'(LAT + 1));
      checkOutput("b2b second data", gData, eData2);
      dmRead = 1'b0;
      @(negedge clk);
      checkOutput("b2b end pulse", 32'(ready), 32'd0);

      // Request dropped during WAIT: no ready, no write.
      dmWen  = 1'b1;
      dmRead = 1'b0;
      dmF3   = 3'b010;
      dmAddr = 32'h200;
      dmWd   = 32'hFFFFFFFF;
      @(negedge clk);
      dmWen = 1'b0;
      checkQuiet("abort no ready", 5);
      refAccess(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, eErr, eData);
      doAccess("abort readback", 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, eErr, eData);

      // Reset asserted during WAIT.
      dmWen = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("rst-wait ready", 32'(ready), 32'd0);
      dmWen = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      checkQuiet("rst-wait no ready", 4);
      doAccess("rst-wait readback", 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, eErr, eData);

      // Reset asserted during the ready cycle of a store.
      dmWen = 1'b1;
      waitReady("rst-resp", lat, gErr, gData);
      checkOutput("rst-resp latency", 32'(lat), 32'(LAT));
      rstN = 1'b0;
      #1;
      checkOutput("rst-resp ready", 32'(ready), 32'd0);
      dmWen = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      doAccess("rst-resp readback", 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, eErr, eData);

      for (int n = 0; n < 300; n++) begin
         r   = int'($urandom_range(0, 99));
         wen = (r >= 55);
         rd  = (r < 55) || (r >= 95);
         if ($urandom_range(0, 9) < 8) begin
            if (wen) begin
               f3 = 3'($urandom_range(0, 2));
            end else begin
               p  = int'($urandom_range(0, 4));
               f3 = (p < 3) ? 3'(p) : 3'(p + 1);
            end
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 9) < 9) addr = 32'($urandom_range(0, SPAN - 1));
         else                          addr = SPAN + 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
         wd = $urandom;
         refAccess(wen, rd, f3, addr, wd, eErr, eData);
         doAccess($sformatf("rand[%0d]", n), wen, rd, f3, addr, wd, eErr, eData);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
